// File: rtl/led_matrix_scan.sv
// Row-multiplexed driver for a 16x16 LED board: snapshots frame_flat once per
// scan and, for each row, shifts 16 column bits out, blanks, latches and lights.
module led_matrix_scan #(
  parameter int CLK_DIV        = 4,
  parameter int BLANK_CYC      = 8,
  parameter int DWELL          = 2000,
  parameter int COL_ACTIVE_LOW = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] frame_flat,
  input  logic         disp_en,
  output logic [3:0]   row_sel,
  output logic         col_sdi,
  output logic         col_sclk,
  output logic         col_latch,
  output logic         oe_n,
  output logic         frame_tick
);

  localparam int TMAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(CLK_DIV + 1);
  localparam logic INV = (COL_ACTIVE_LOW != 0);

  typedef enum logic [2:0] {LOAD, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t         state, state_d;
  logic [255:0]   frame_buf, frame_buf_d;
  logic [14:0]    sr, sr_d;
  logic [3:0]     row_cnt, row_cnt_d;
  logic [3:0]     bit_cnt, bit_cnt_d;
  logic [DW-1:0]  div_cnt, div_cnt_d;
  logic [TW-1:0]  cnt, cnt_d;
  logic [3:0]     row_sel_d;
  logic           col_sdi_d, col_sclk_d, col_latch_d, oe_n_d, frame_tick_d;
  logic [15:0]    load_bits;

  // Column c of row r sits at bit 16*c + r, i.e. index {c, r}.
  function automatic logic [15:0] row_bits(input logic [255:0] src, input logic [3:0] r);
    logic [15:0] b;
    for (int c = 0; c < 16; c++) b[c] = src[{4'(c), r}];
    return b;
  endfunction

  // Row 0 reads frame_flat directly so the fresh snapshot is used, not the stale buffer.
  assign load_bits = row_bits((row_cnt == 4'd0) ? frame_flat : frame_buf, row_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      frame_buf  <= '0;
      sr         <= '0;
      row_cnt    <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      cnt        <= '0;
      row_sel    <= '0;
      col_sdi    <= 1'b0;
      col_sclk   <= 1'b0;
      col_latch  <= 1'b0;
      oe_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_d;
      frame_buf  <= frame_buf_d;
      sr         <= sr_d;
      row_cnt    <= row_cnt_d;
      bit_cnt    <= bit_cnt_d;
      div_cnt    <= div_cnt_d;
      cnt        <= cnt_d;
      row_sel    <= row_sel_d;
      col_sdi    <= col_sdi_d;
      col_sclk   <= col_sclk_d;
      col_latch  <= col_latch_d;
      oe_n       <= oe_n_d;
      frame_tick <= frame_tick_d;
    end
  end

  // Outputs are computed as next-cycle register values, so nothing reaches a pin combinationally.
  always_comb begin
    state_d      = state;
    frame_buf_d  = frame_buf;
    sr_d         = sr;
    row_cnt_d    = row_cnt;
    bit_cnt_d    = bit_cnt;
    div_cnt_d    = div_cnt;
    cnt_d        = cnt;
    row_sel_d    = row_sel;
    col_sdi_d    = col_sdi;
    col_sclk_d   = col_sclk;
    col_latch_d  = 1'b0;
    oe_n_d       = oe_n;
    frame_tick_d = 1'b0;

    case (state)
      LOAD: begin
        if (row_cnt == 4'd0) begin
          frame_buf_d  = frame_flat;
          frame_tick_d = 1'b1;
        end
        sr_d       = load_bits[14:0];
        col_sdi_d  = load_bits[15] ^ INV;
        col_sclk_d = 1'b0;
        div_cnt_d  = '0;
        bit_cnt_d  = '0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          if (!col_sclk) begin
            col_sclk_d = 1'b1;
          end else if (bit_cnt == 4'd15) begin
            col_sclk_d = 1'b0;
            oe_n_d     = 1'b1;
            cnt_d      = '0;
            state_d    = BLANK;
          end else begin
            // New data bit only ever appears together with the falling clock.
            col_sclk_d = 1'b0;
            col_sdi_d  = sr[14] ^ INV;
            sr_d       = {sr[13:0], 1'b0};
            bit_cnt_d  = bit_cnt + 4'd1;
          end
        end else begin
          div_cnt_d = div_cnt + DW'(1);
        end
      end
      BLANK: begin
        if (cnt == TW'(BLANK_CYC - 1)) begin
          col_latch_d = 1'b1;
          row_sel_d   = row_cnt;
          state_d     = LATCH;
        end else begin
          cnt_d = cnt + TW'(1);
        end
      end
      LATCH: begin
        oe_n_d  = ~disp_en;
        cnt_d   = '0;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        oe_n_d = ~disp_en;
        if (cnt == TW'(DWELL - 1)) begin
          row_cnt_d = row_cnt + 4'd1;
          state_d   = LOAD;
        end else begin
          cnt_d = cnt + TW'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: instance 0 uses default timing, instance 1 a fast
// active-low configuration; a monitor decodes the serial stream per latch.
module tb_led_matrix_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst_n   [2];
  logic [255:0] frame   [2];
  logic         disp_en [2];
  logic [3:0]   rs      [2];
  logic         sdi     [2];
  logic         sclk    [2];
  logic         lat     [2];
  logic         oen     [2];
  logic         tick    [2];

  led_matrix_scan u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .frame_flat(frame[0]), .disp_en(disp_en[0]),
    .row_sel(rs[0]), .col_sdi(sdi[0]), .col_sclk(sclk[0]), .col_latch(lat[0]),
    .oe_n(oen[0]), .frame_tick(tick[0])
  );

  led_matrix_scan #(.CLK_DIV(1), .BLANK_CYC(2), .DWELL(4), .COL_ACTIVE_LOW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .frame_flat(frame[1]), .disp_en(disp_en[1]),
    .row_sel(rs[1]), .col_sdi(sdi[1]), .col_sclk(sclk[1]), .col_latch(lat[1]),
    .oe_n(oen[1]), .frame_tick(tick[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          lat_cnt[2], lat_cyc[2], prev_lat_cyc[2], lat_rises[2], lat_oe_run[2];
  int          tick_cnt[2], tick_cyc[2], prev_tick_cyc[2];
  int          rises[2], oe_run[2], viol[2], bad_space[2], last_rise[2], oe_low[2];
  logic [15:0] word[2], lat_word[2];
  logic [3:0]  lat_row[2];
  logic        prev_sclk[2], prev_sdi[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      lat_cnt[k] = 0; lat_cyc[k] = 0; prev_lat_cyc[k] = 0; lat_rises[k] = 0;
      lat_oe_run[k] = 0; tick_cnt[k] = 0; tick_cyc[k] = 0; prev_tick_cyc[k] = 0;
      viol[k] = 0; bad_space[k] = 0; oe_low[k] = 0;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_mon
    localparam int DIVK = (k == 0) ? 4 : 1;
    always @(negedge clk) begin
      if (!rst_n[k]) begin
        word[k] <= '0; rises[k] <= 0; oe_run[k] <= 0;
        prev_sclk[k] <= 1'b0; prev_sdi[k] <= 1'b0; last_rise[k] <= -1;
      end else begin
        if (sclk[k] && !prev_sclk[k]) begin
          word[k] <= {word[k][14:0], sdi[k]};
          if (rises[k] > 0 && cyc - last_rise[k] != 2 * DIVK) bad_space[k] <= bad_space[k] + 1;
          last_rise[k] <= cyc;
          rises[k] <= rises[k] + 1;
        end
        if (sdi[k] != prev_sdi[k] && sclk[k] && prev_sclk[k]) viol[k] <= viol[k] + 1;
        if (!oen[k]) oe_low[k] <= oe_low[k] + 1;
        if (lat[k]) begin
          lat_word[k] <= word[k]; lat_row[k] <= rs[k]; lat_rises[k] <= rises[k];
          lat_oe_run[k] <= oe_run[k]; prev_lat_cyc[k] <= lat_cyc[k]; lat_cyc[k] <= cyc;
          lat_cnt[k] <= lat_cnt[k] + 1; rises[k] <= 0; word[k] <= '0;
        end
        oe_run[k] <= oen[k] ? oe_run[k] + 1 : 0;
        if (tick[k]) begin
          prev_tick_cyc[k] <= tick_cyc[k]; tick_cyc[k] <= cyc; tick_cnt[k] <= tick_cnt[k] + 1;
        end
        prev_sclk[k] <= sclk[k];
        prev_sdi[k]  <= sdi[k];
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_latch(input int k, input int budget, input string name);
    int start = lat_cnt[k];
    int n = 0;
    while (lat_cnt[k] == start && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (lat_cnt[k] == start) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no col_latch within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_tick(input int k, input int budget, input string name);
    int start = tick_cnt[k];
    int n = 0;
    while (tick_cnt[k] == start && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (tick_cnt[k] == start) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no frame_tick within %0d cycles", name, budget);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [255:0] f, input int r, input bit inv);
    logic [15:0] w;
    for (int c = 0; c < 16; c++) w[c] = f[16 * c + r] ^ inv;
    return w;
  endfunction

  typedef struct {
    int          row;
    logic [15:0] word;
  } row_vec_t;

  typedef struct {
    logic [255:0] frame;
    logic         de;
    int           row;
    logic [15:0]  word;
  } frame_vec_t;

  // Default timing: 2138 cycles per row, 34208 per frame.
  task automatic run_dut0();
    row_vec_t pix_tab[16];
    int rel;
    for (int i = 0; i < 16; i++) begin pix_tab[i].row = i; pix_tab[i].word = 16'h0000; end
    pix_tab[5].word = 16'h0008;

    rst_n[0] = 1'b0; frame[0] = '0; frame[0][53] = 1'b1; disp_en[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("d0 reset oe_n", oen[0], 1);
    check("d0 reset row_sel", rs[0], 0);
    check("d0 reset sclk", sclk[0], 0);
    check("d0 reset sdi", sdi[0], 0);
    check("d0 reset latch", lat[0], 0);
    check("d0 reset tick", tick[0], 0);

    @(negedge clk); rel = cyc; rst_n[0] = 1'b1;
    @(posedge clk); #1;
    check("d0 tick first cycle", tick[0], 1);
    @(posedge clk); #1;
    check("d0 tick one cycle", tick[0], 0);

    for (int i = 0; i < 16; i++) begin
      wait_latch(0, 3000, "d0 row latch");
      check($sformatf("d0 row%0d row_sel", i), lat_row[0], pix_tab[i].row);
      check($sformatf("d0 row%0d word", i), lat_word[0], pix_tab[i].word);
      check($sformatf("d0 row%0d sclk rises", i), lat_rises[0], 16);
      check($sformatf("d0 row%0d blank>=8", i), lat_oe_run[0] >= 8, 1);
      if (i > 0) check($sformatf("d0 row%0d period", i), lat_cyc[0] - prev_lat_cyc[0], 2138);
    end
    check("d0 first tick cycle", prev_tick_cyc[0] == 0 ? tick_cyc[0] - rel : 0, 1);
    wait_tick(0, 3000, "d0 second tick");
    check("d0 frame period", tick_cyc[0] - prev_tick_cyc[0], 34208);

    for (int i = 0; i < 7; i++) wait_latch(0, 3000, "d0 frame2 latch");
    check("d0 row6 before reset", lat_row[0], 6);
    repeat (2050) @(posedge clk);
    #3 rst_n[0] = 1'b0;
    #1;
    check("d0 async oe_n", oen[0], 1);
    check("d0 async row_sel", rs[0], 0);
    check("d0 async sclk", sclk[0], 0);
    check("d0 async sdi", sdi[0], 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rel = cyc; rst_n[0] = 1'b1;
    wait_latch(0, 3000, "d0 restart latch");
    check("d0 restart row_sel", lat_row[0], 0);
    check("d0 restart latch delay", lat_cyc[0] - rel, 1 + 32 * 4 + 8);
    check("d0 restart tick", tick_cyc[0] - rel, 1);
    check("d0 sdi stable while sclk high", viol[0], 0);
    check("d0 sclk period 8", bad_space[0], 0);
  endtask

  // CLK_DIV=1, BLANK_CYC=2, DWELL=4, inverted columns: 40 cycles per row, 640 per frame.
  task automatic run_dut1();
    frame_vec_t vtab[5];
    int low0;
    vtab[0].frame = '0; vtab[0].de = 1'b1; vtab[0].row = 0;  vtab[0].word = 16'hFFFF;
    vtab[1].frame = '0; vtab[1].frame[9] = 1'b1;
    vtab[1].de = 1'b1; vtab[1].row = 9;  vtab[1].word = 16'hFFFE;
    vtab[2].frame = '0; vtab[2].frame[242] = 1'b1;
    vtab[2].de = 1'b1; vtab[2].row = 2;  vtab[2].word = 16'h7FFF;
    vtab[3].frame = '0; vtab[3].frame[116] = 1'b1; vtab[3].frame[132] = 1'b1;
    vtab[3].de = 1'b1; vtab[3].row = 4;  vtab[3].word = 16'hFE7F;
    vtab[4].frame = '1; vtab[4].de = 1'b0; vtab[4].row = 11; vtab[4].word = 16'h0000;

    rst_n[1] = 1'b0; frame[1] = '1; disp_en[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("d1 reset oe_n", oen[1], 1);
    @(negedge clk); rst_n[1] = 1'b1;
    wait_tick(1, 10, "d1 first tick");

    for (int r = 0; r < 16; r++) begin
      wait_latch(1, 100, "d1 anti-tear latch");
      if (r == 2) frame[1] = '0;
      check($sformatf("d1 anti-tear row%0d", r), lat_word[1], 16'h0000);
    end
    wait_latch(1, 100, "d1 next frame latch");
    check("d1 next frame row_sel", lat_row[1], 0);
    check("d1 next frame word", lat_word[1], 16'hFFFF);
    check("d1 frame period", tick_cyc[1] - prev_tick_cyc[1], 640);

    for (int v = 0; v < 5; v++) begin
      frame[1] = vtab[v].frame; disp_en[1] = vtab[v].de;
      wait_tick(1, 700, "d1 table tick");
      low0 = 0;
      for (int r = 0; r < 16; r++) begin
        wait_latch(1, 100, "d1 table latch");
        if (r == 0) low0 = oe_low[1];
        check($sformatf("d1 v%0d row%0d row_sel", v, r), lat_row[1], r);
        check($sformatf("d1 v%0d row%0d model", v, r), lat_word[1], exp_word(vtab[v].frame, r, 1'b1));
        check($sformatf("d1 v%0d row%0d rises", v, r), lat_rises[1], 16);
        if (r == vtab[v].row) check($sformatf("d1 v%0d row%0d word", v, r), lat_word[1], vtab[v].word);
        if (r > 0) check($sformatf("d1 v%0d row period", v), lat_cyc[1] - prev_lat_cyc[1], 40);
      end
      if (vtab[v].de) check($sformatf("d1 v%0d lit", v), oe_low[1] > low0, 1);
      else check($sformatf("d1 v%0d dark", v), oe_low[1] - low0, 0);
    end

    wait_latch(1, 100, "d1 toggle latch");
    check("d1 display off", oen[1], 1);
    disp_en[1] = 1'b1;
    @(posedge clk); #1 check("d1 enable next cycle", oen[1], 0);
    disp_en[1] = 1'b0;
    @(posedge clk); #1 check("d1 disable next cycle", oen[1], 1);
    check("d1 sdi stable while sclk high", viol[1], 0);
    check("d1 sclk period 2", bad_space[1], 0);
  endtask

  initial begin
    fork
      run_dut0();
      run_dut1();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
